// File: rtl/rs_enc_pkg.sv
// Shared constants and FSM state type for the RS(16,8) encoder front end.
package rs_enc_pkg;

    localparam int unsigned RS_MSG_LEN = 8;
    localparam int unsigned RS_PAR_LEN = 8;
    localparam int unsigned RS_SYM_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } framer_state_t;

endpackage

// File: rtl/rs_byte_fifo.sv
// Synchronous show-ahead FIFO; the head entry is always visible on rd_data.
module rs_byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem[rd_ptr_q];

    // A read frees the slot in the same edge, so a full FIFO may take a write alongside it.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rs_msg_framer.sv
// Frames a byte stream into MSG_LEN-byte messages with a PAR_LEN-cycle parity gap.
// Define RS_FRAMER_PAD_EN to close short packets on in_last and zero-pad them.
module rs_msg_framer
    import rs_enc_pkg::*;
#(
    parameter int unsigned MSG_LEN    = RS_MSG_LEN,
    parameter int unsigned PAR_LEN    = RS_PAR_LEN,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RS_SYM_W-1:0] in_data,
    input  logic                in_last,
    output logic                enc_val,
    output logic                enc_sop,
    output logic [RS_SYM_W-1:0] enc_data,
    output logic                busy
);

    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW   = $clog2(MSG_LEN + 1);
    localparam int unsigned MAXL = (MSG_LEN > PAR_LEN) ? MSG_LEN : PAR_LEN;
    localparam int unsigned SW   = $clog2(MAXL + 1);
`ifdef RS_FRAMER_PAD_EN
    localparam int unsigned FW = RS_SYM_W + 1;
`else
    localparam int unsigned FW = RS_SYM_W;
`endif

    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_full;
    logic                fifo_empty_unused;
    logic [CW-1:0]       fifo_count;
    logic [FW-1:0]       fifo_wdata;
    logic [FW-1:0]       fifo_rdata;
    logic [RS_SYM_W-1:0] head_byte;
    logic                head_last;
    logic                wr_last;
    logic                close_blk;
    logic                start_msg;

    framer_state_t       state_q, state_d;
    logic [BW-1:0]       blk_cnt_q, blk_cnt_d;
    logic [CW-1:0]       pend_q, pend_d;
    logic [SW-1:0]       msg_cnt_q, msg_cnt_d;
    logic                pad_q, pad_d;
    logic                enc_val_q, enc_val_d;
    logic                enc_sop_q, enc_sop_d;
    logic [RS_SYM_W-1:0] enc_data_q, enc_data_d;

`ifdef RS_FRAMER_PAD_EN
    assign fifo_wdata = {in_last, in_data};
    assign head_last  = fifo_rdata[RS_SYM_W];
    assign wr_last    = in_last;
`else
    logic in_last_unused;
    assign in_last_unused = in_last;
    assign fifo_wdata     = in_data;
    assign head_last      = 1'b0;
    assign wr_last        = 1'b0;
`endif
    assign head_byte = fifo_rdata[RS_SYM_W-1:0];

    rs_byte_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty_unused),
        .count   (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign fifo_wr   = in_valid && in_ready;
    assign close_blk = fifo_wr && ((blk_cnt_q == BW'(MSG_LEN - 1)) || wr_last);

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (fifo_wr) begin
            blk_cnt_d = close_blk ? '0 : blk_cnt_q + 1'b1;
        end
        unique case ({close_blk, start_msg})
            2'b10:   pend_d = pend_q + 1'b1;
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase
    end

    // Output registers load on the same edge as the state they belong to, so
    // enc_val_q is high exactly while state_q is SEND.
    always_comb begin
        state_d    = state_q;
        msg_cnt_d  = msg_cnt_q;
        pad_d      = pad_q;
        enc_val_d  = 1'b0;
        enc_sop_d  = 1'b0;
        enc_data_d = enc_data_q;
        fifo_rd    = 1'b0;
        start_msg  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    start_msg  = 1'b1;
                    state_d    = SEND;
                    msg_cnt_d  = '0;
                    enc_val_d  = 1'b1;
                    enc_sop_d  = 1'b1;
                    enc_data_d = head_byte;
                    fifo_rd    = 1'b1;
                    pad_d      = head_last;
                end
            end
            SEND: begin
                if (msg_cnt_q == SW'(MSG_LEN - 1)) begin
                    state_d   = GAP;
                    msg_cnt_d = '0;
                end else begin
                    msg_cnt_d = msg_cnt_q + 1'b1;
                    enc_val_d = 1'b1;
                    if (pad_q) begin
                        enc_data_d = '0;
                    end else begin
                        enc_data_d = head_byte;
                        fifo_rd    = 1'b1;
                        pad_d      = head_last;
                    end
                end
            end
            GAP: begin
                if (msg_cnt_q == SW'(PAR_LEN - 1)) begin
                    state_d   = IDLE;
                    msg_cnt_d = '0;
                end else begin
                    msg_cnt_d = msg_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            blk_cnt_q  <= '0;
            pend_q     <= '0;
            msg_cnt_q  <= '0;
            pad_q      <= 1'b0;
            enc_val_q  <= 1'b0;
            enc_sop_q  <= 1'b0;
            enc_data_q <= '0;
        end else begin
            state_q    <= state_d;
            blk_cnt_q  <= blk_cnt_d;
            pend_q     <= pend_d;
            msg_cnt_q  <= msg_cnt_d;
            pad_q      <= pad_d;
            enc_val_q  <= enc_val_d;
            enc_sop_q  <= enc_sop_d;
            enc_data_q <= enc_data_d;
        end
    end

    assign enc_val  = enc_val_q;
    assign enc_sop  = enc_sop_q;
    assign enc_data = enc_data_q;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_rs_msg_framer.sv
// Randomised bench for rs_msg_framer against a queue-based message model.
module tb_rs_msg_framer;

    localparam int DEPTH = 16;
    localparam int MSG   = 8;
`ifdef RS_FRAMER_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       enc_val;
    logic       enc_sop;
    logic [7:0] enc_data;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc_cyc;
    bit full_seen;
    bit full_bad;

    logic [8:0] acc_q[$];   // accepted {last, byte}
    logic [7:0] obs_d[$];
    bit         obs_s[$];
    int         obs_c[$];
    logic [7:0] exp_d[$];
    bit         exp_s[$];

    rs_msg_framer dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .enc_val  (enc_val),
        .enc_sop  (enc_sop),
        .enc_data (enc_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture outputs and accepted inputs away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (enc_val) begin
                obs_d.push_back(enc_data);
                obs_s.push_back(enc_sop);
                obs_c.push_back(cyc);
            end
            if (!in_ready) begin
                full_seen = 1'b1;
                if (acc_q.size() - obs_d.size() != DEPTH) full_bad = 1'b1;
            end
            if (in_valid && in_ready) acc_q.push_back({in_last, in_data});
        end
    end

    // Reference: consecutive groups of MSG bytes, or shorter groups closed by last
    // (pad build only) and zero-filled; an unfinished group produces nothing.
    task automatic build_expected();
        logic [7:0] msg[$];
        exp_d.delete();
        exp_s.delete();
        foreach (acc_q[i]) begin
            msg.push_back(acc_q[i][7:0]);
            if (msg.size() == MSG || (PAD && acc_q[i][8])) begin
                for (int k = 0; k < MSG; k++) begin
                    exp_d.push_back(k < msg.size() ? msg[k] : 8'h00);
                    exp_s.push_back(k == 0);
                end
                msg.delete();
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input logic l);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                last_acc_cyc = cyc;
                @(posedge clk);
                #1;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: in_ready=%b for 200 cycles, required 1", in_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input string nm);
        for (int i = 0; i < 3000 && obs_d.size() < n; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_d.size() < n) begin
            n_err++;
            $display("FAIL %s_wait: got %0d output bytes, required %0d", nm, obs_d.size(), n);
        end
    endtask

    task automatic clear_model();
        acc_q.delete();
        obs_d.delete();
        obs_s.delete();
        obs_c.delete();
        full_seen = 1'b0;
        full_bad  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            n_cmp += 4;
            if (enc_val !== 1'b0) begin n_err++; $display("FAIL rst_val: got %b, required 0", enc_val); end
            if (enc_sop !== 1'b0) begin n_err++; $display("FAIL rst_sop: got %b, required 0", enc_sop); end
            if (enc_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h, required 00", enc_data); end
            if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clear_model();
        @(negedge clk);
        n_cmp += 2;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b, required 1", in_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b, required 0", busy); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_message();
        for (int b = 1; b <= 8; b++) push_byte(8'(b), 1'b0);
        idle_cycles(0);
        wait_obs(8, "single");
        idle_cycles(20);
        build_expected();
        n_cmp++;
        if (obs_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL single_len: got %0d bytes, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            n_cmp++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
                n_err++;
                $display("FAIL single_byte%0d: got %h/sop%b, required %h/sop%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            end
        end
        if (obs_c.size() == 8) begin
            n_cmp++;
            if (obs_c[0] !== last_acc_cyc + 2) begin
                n_err++;
                $display("FAIL single_latency: sop at cycle %0d, required %0d",
                         obs_c[0], last_acc_cyc + 2);
            end
            n_cmp++;
            if (obs_c[7] - obs_c[0] !== 7) begin
                n_err++;
                $display("FAIL single_contig: span %0d cycles, required 7", obs_c[7] - obs_c[0]);
            end
        end
    endtask

    task automatic test_fill();
        int base;
        base = obs_d.size();
        full_seen = 1'b0;
        full_bad  = 1'b0;
        for (int b = 0; b < 24; b++) push_byte(8'(b), 1'b0);
        idle_cycles(0);
        wait_obs(base + 24, "fill");
        idle_cycles(20);
        build_expected();
        n_cmp++;
        if (obs_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL fill_len: got %0d bytes, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            n_cmp++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
                n_err++;
                $display("FAIL fill_byte%0d: got %h/sop%b, required %h/sop%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            end
        end
        n_cmp += 2;
        if (full_seen !== 1'b1) begin n_err++; $display("FAIL fill_ready_drop: seen %b, required 1", full_seen); end
        if (full_bad !== 1'b0) begin n_err++; $display("FAIL fill_ready_level: early drop %b, required 0", full_bad); end
        for (int m = 1; m < 3 && base + 8 * m < obs_c.size(); m++) begin
            n_cmp++;
            if (obs_c[base + 8 * m] - obs_c[base + 8 * (m - 1)] < 17) begin
                n_err++;
                $display("FAIL fill_period%0d: got %0d cycles, required >=17",
                         m, obs_c[base + 8 * m] - obs_c[base + 8 * (m - 1)]);
            end
        end
    endtask

`ifdef RS_FRAMER_PAD_EN
    task automatic test_pad();
        int base;
        base = obs_d.size();
        push_byte(8'hA1, 1'b0);
        push_byte(8'hA2, 1'b0);
        push_byte(8'hA3, 1'b1);
        idle_cycles(0);
        wait_obs(base + 8, "pad");
        idle_cycles(20);
        build_expected();
        n_cmp++;
        if (obs_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL pad_len: got %0d bytes, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = base; i < obs_d.size() && i < exp_d.size(); i++) begin
            n_cmp++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
                n_err++;
                $display("FAIL pad_byte%0d: got %h/sop%b, required %h/sop%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            end
        end
    endtask
`else
    task automatic test_partial();
        int base;
        base = obs_d.size();
        push_byte(8'hA1, 1'b0);
        push_byte(8'hA2, 1'b0);
        push_byte(8'hA3, 1'b1);
        idle_cycles(40);
        n_cmp += 2;
        if (obs_d.size() != base) begin
            n_err++;
            $display("FAIL partial_hold: got %0d output bytes, required %0d", obs_d.size(), base);
        end
        if (busy !== 1'b1) begin n_err++; $display("FAIL partial_busy: got %b, required 1", busy); end
        for (int b = 1; b <= 5; b++) push_byte(8'hB0 + 8'(b), 1'b0);
        idle_cycles(0);
        wait_obs(base + 8, "partial");
        idle_cycles(20);
        build_expected();
        n_cmp++;
        if (obs_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL partial_len: got %0d bytes, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = base; i < obs_d.size() && i < exp_d.size(); i++) begin
            n_cmp++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
                n_err++;
                $display("FAIL partial_byte%0d: got %h/sop%b, required %h/sop%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            push_byte(8'($urandom), 1'($urandom_range(0, 5) == 0));
            idle_cycles($urandom_range(0, 3));
        end
        idle_cycles(0);
        build_expected();
        wait_obs(exp_d.size(), "random");
        idle_cycles(30);
        n_cmp++;
        if (obs_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL random_len: got %0d bytes, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            n_cmp++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
                n_err++;
                $display("FAIL random_byte%0d: got %h/sop%b, required %h/sop%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        test_reset();
        for (int b = 0; b < 8; b++) push_byte(8'($urandom), 1'b0);
        idle_cycles(0);
        for (int i = 0; i < 200 && obs_d.size() < 3; i++) @(posedge clk);
        // The edge just seen loads the 4th byte; reset is sampled on the next one.
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp += 3;
        if (enc_val !== 1'b0) begin n_err++; $display("FAIL abort_val: got %b, required 0", enc_val); end
        if (enc_sop !== 1'b0) begin n_err++; $display("FAIL abort_sop: got %b, required 0", enc_sop); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, required 0", busy); end
        clear_model();
        @(posedge clk);
        #1;
        for (int b = 0; b < 8; b++) push_byte(8'($urandom), 1'b0);
        idle_cycles(0);
        wait_obs(8, "after_abort");
        idle_cycles(20);
        build_expected();
        n_cmp++;
        if (obs_d.size() != exp_d.size()) begin
            n_err++;
            $display("FAIL after_abort_len: got %0d bytes, required %0d", obs_d.size(), exp_d.size());
        end
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++) begin
            n_cmp++;
            if (obs_d[i] !== exp_d[i] || obs_s[i] !== exp_s[i]) begin
                n_err++;
                $display("FAIL after_abort_byte%0d: got %h/sop%b, required %h/sop%b",
                         i, obs_d[i], obs_s[i], exp_d[i], exp_s[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_message();
        test_fill();
`ifdef RS_FRAMER_PAD_EN
        test_pad();
`else
        test_partial();
`endif
        test_random();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
